// File: rtl/pic_interrupt_control.sv
// -----------------------------------------------------------------------------
// pic_interrupt_control
//
// Interrupt control stage of an 8259-style PIC, downstream of the priority
// resolver. It runs the 8086-mode two-pulse INTA handshake, owns the
// in-service register and EOI processing, and feeds the isr and rotation
// point back to the resolver.
//
// Ports:
//   clk                  system clock, rising edge
//   rst_n                asynchronous active-low reset
//   interrupt_vector_i   one-hot request from the resolver, 0 = none
//   inta_n_i             CPU acknowledge, active low, synchronous to clk
//   vector_base_i        ICW2 T7..T3
//   eoi_i                one-cycle EOI command strobe
//   specific_eoi_i       1 = clear eoi_level_i, 0 = non-specific EOI
//   eoi_level_i          level addressed by a specific EOI
//   rotate_on_eoi_i      rotate lowest priority to the cleared level
//   int_o                interrupt request to the CPU
//   isr_o                in-service register
//   priority_rotate_o    current lowest-priority level
//   clear_irr_o          one-cycle one-hot pulse clearing the serviced IRR bit
//   data_out_o           vector byte
//   data_out_en_o        data bus drive enable
//
// Build option:
//   AUTO_EOI_EN  when defined, the rise ending the second INTA pulse clears
//                the in-service bit of the acknowledged level.
// -----------------------------------------------------------------------------
module pic_interrupt_control #(
  parameter int VECTOR_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [VECTOR_W-1:0] interrupt_vector_i,
  input  logic                inta_n_i,
  input  logic [4:0]          vector_base_i,
  input  logic                eoi_i,
  input  logic                specific_eoi_i,
  input  logic [2:0]          eoi_level_i,
  input  logic                rotate_on_eoi_i,
  output logic                int_o,
  output logic [VECTOR_W-1:0] isr_o,
  output logic [2:0]          priority_rotate_o,
  output logic [VECTOR_W-1:0] clear_irr_o,
  output logic [VECTOR_W-1:0] data_out_o,
  output logic                data_out_en_o
);

  localparam logic [VECTOR_W-1:0] ONE = {{(VECTOR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK1 = 2'd2,
    S_ACK2 = 2'd3
  } state_t;

  state_t              state_q;
  logic                inta_n_q;
  logic                int_q;
  logic [VECTOR_W-1:0] isr_q;
  logic [VECTOR_W-1:0] isr_d;
  logic [2:0]          prio_q;
  logic [2:0]          prio_d;
  logic [VECTOR_W-1:0] clear_irr_q;
  logic [VECTOR_W-1:0] data_out_q;
  logic                data_out_en_q;
  logic [2:0]          level_q;
`ifdef AUTO_EOI_EN
  logic                spurious_q;
`endif

  logic                fall;
  logic                rise;
  logic                vec_any;
  logic [2:0]          req_lvl;
  logic [VECTOR_W-1:0] set_mask;
  logic                eoi_hit;
  logic [2:0]          eoi_lvl;
  logic [3:0]          rot_res;
  logic [VECTOR_W-1:0] eoi_mask;
  logic [VECTOR_W-1:0] auto_mask;

  // Index of the lowest set bit; 7 when nothing is set.
  function automatic logic [2:0] lowest_idx(input logic [VECTOR_W-1:0] v);
    lowest_idx = 3'd7;
    for (int i = VECTOR_W - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[2:0];
    end
  endfunction

  // Non-specific EOI target: first set isr bit starting one above the
  // lowest-priority level and wrapping. Returns {found, level}.
  function automatic logic [3:0] rot_search(input logic [VECTOR_W-1:0] v,
                                            input logic [2:0]          prio);
    logic       found;
    logic [2:0] idx;
    logic [2:0] sel;
    found = 1'b0;
    sel   = 3'd0;
    for (int i = 0; i < VECTOR_W; i++) begin
      idx = prio + 3'd1 + i[2:0];
      if (!found && v[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    rot_search = {found, sel};
  endfunction

  assign fall    = inta_n_q & ~inta_n_i;
  assign rise    = ~inta_n_q & inta_n_i;
  assign vec_any = |interrupt_vector_i;
  assign req_lvl = lowest_idx(interrupt_vector_i);
  assign rot_res = rot_search(isr_q, prio_q);

  always_comb begin
    set_mask = '0;
    if (state_q == S_REQ && fall && vec_any) set_mask = ONE << req_lvl;

    // EOI selection always looks at the isr before this cycle's set.
    eoi_hit = 1'b0;
    eoi_lvl = 3'd0;
    if (eoi_i) begin
      if (specific_eoi_i) begin
        eoi_hit = isr_q[eoi_level_i];
        eoi_lvl = eoi_level_i;
      end else begin
        eoi_hit = rot_res[3];
        eoi_lvl = rot_res[2:0];
      end
    end
    eoi_mask = eoi_hit ? (ONE << eoi_lvl) : '0;

    auto_mask = '0;
`ifdef AUTO_EOI_EN
    if (state_q == S_ACK2 && rise && !spurious_q) auto_mask = ONE << level_q;
`endif

    // OR-ing the set last lets a same-cycle set win over an EOI clear.
    isr_d  = (isr_q & ~eoi_mask & ~auto_mask) | set_mask;
    prio_d = (eoi_hit && rotate_on_eoi_i) ? eoi_lvl : prio_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      inta_n_q      <= 1'b1;
      int_q         <= 1'b0;
      isr_q         <= '0;
      prio_q        <= 3'd7;
      clear_irr_q   <= '0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
      level_q       <= 3'd7;
`ifdef AUTO_EOI_EN
      spurious_q    <= 1'b0;
`endif
    end else begin
      inta_n_q    <= inta_n_i;
      isr_q       <= isr_d;
      prio_q      <= prio_d;
      clear_irr_q <= '0;
      case (state_q)
        S_IDLE: begin
          // inta_n activity here is ignored; only a request moves us on.
          if (vec_any) begin
            int_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (fall) begin
            int_q   <= 1'b0;
            state_q <= S_ACK1;
            if (vec_any) begin
              level_q     <= req_lvl;
              clear_irr_q <= set_mask;
`ifdef AUTO_EOI_EN
              spurious_q  <= 1'b0;
`endif
            end else begin
              // Request vanished under the acknowledge: answer with IR7.
              level_q     <= 3'd7;
`ifdef AUTO_EOI_EN
              spurious_q  <= 1'b1;
`endif
            end
          end else if (!vec_any) begin
            int_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_ACK1: begin
          // inta_n is low on entry, so a fall implies the rise already passed.
          if (fall) begin
            data_out_q    <= {vector_base_i, level_q};
            data_out_en_q <= 1'b1;
            state_q       <= S_ACK2;
          end
        end
        S_ACK2: begin
          if (rise) begin
            data_out_en_q <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign int_o             = int_q;
  assign isr_o             = isr_q;
  assign priority_rotate_o = prio_q;
  assign clear_irr_o       = clear_irr_q;
  assign data_out_o        = data_out_q;
  assign data_out_en_o     = data_out_en_q;

endmodule
